// File: rtl/demux_1x3_buf.sv
// Registered 1:3 demux: one input word steered to one of three one-entry output slots.
// Latency: an accepted word appears on its slot one clock after the accept edge.
// Backpressure: in_ready drops only when the targeted slot is full and its consumer is not draining it.
module demux_1x3_buf #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  demux_in,
  input  logic [1:0]             select_1x3,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_00,
  output logic [DATA_WIDTH-1:0]  out_01,
  output logic [DATA_WIDTH-1:0]  out_10,
  output logic                   out_valid_00,
  output logic                   out_valid_01,
  output logic                   out_valid_10,
  input  logic                   out_ready_00,
  input  logic                   out_ready_01,
  input  logic                   out_ready_10,
  output logic [COUNT_WIDTH-1:0] count_00,
  output logic [COUNT_WIDTH-1:0] count_01,
  output logic [COUNT_WIDTH-1:0] count_10
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  // Slot state kept as unpacked arrays so each slot's register has a single driving block.
  logic                   slot_vld [3];
  logic [DATA_WIDTH-1:0]  slot_dat [3];
  logic [COUNT_WIDTH-1:0] slot_cnt [3];
  logic                   slot_rdy [3];
  logic                   tgt      [3];
  logic                   tgt_vld;
  logic                   tgt_rdy;
  logic                   accept;

  assign slot_rdy[0] = out_ready_00;
  assign slot_rdy[1] = out_ready_01;
  assign slot_rdy[2] = out_ready_10;

  // Decode select with the same priority as the 3:1 selectors: bit 1 wins, 10 and 11 both hit slot 10.
  always_comb begin
    tgt[0]  = 1'b0;
    tgt[1]  = 1'b0;
    tgt[2]  = 1'b0;
    tgt_vld = 1'b0;
    tgt_rdy = 1'b0;
    if (select_1x3[1]) begin
      tgt[2]  = 1'b1;
      tgt_vld = slot_vld[2];
      tgt_rdy = slot_rdy[2];
    end else if (select_1x3[0]) begin
      tgt[1]  = 1'b1;
      tgt_vld = slot_vld[1];
      tgt_rdy = slot_rdy[1];
    end else begin
      tgt[0]  = 1'b1;
      tgt_vld = slot_vld[0];
      tgt_rdy = slot_rdy[0];
    end
  end

  // A full slot still accepts when its consumer drains it on the same edge, giving 1 word/cycle per slot.
  assign in_ready = !reset && (!tgt_vld || tgt_rdy);
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < 3; k++) begin : g_slot
    // One-entry holding register: a load beats a simultaneous drain; data holds once drained.
    always_ff @(posedge clk) begin
      if (reset) begin
        slot_vld[k] <= 1'b0;
        slot_dat[k] <= '0;
        slot_cnt[k] <= '0;
      end else if (accept && tgt[k]) begin
        slot_vld[k] <= 1'b1;
        slot_dat[k] <= demux_in;
        slot_cnt[k] <= (slot_cnt[k] == CNT_MAX) ? slot_cnt[k] : slot_cnt[k] + 1'b1;
      end else if (slot_vld[k] && slot_rdy[k]) begin
        slot_vld[k] <= 1'b0;
      end
    end
  end

  assign out_00       = slot_dat[0];
  assign out_01       = slot_dat[1];
  assign out_10       = slot_dat[2];
  assign out_valid_00 = slot_vld[0];
  assign out_valid_01 = slot_vld[1];
  assign out_valid_10 = slot_vld[2];
  assign count_00     = slot_cnt[0];
  assign count_01     = slot_cnt[1];
  assign count_10     = slot_cnt[2];

endmodule

// File: tb/tb_demux_1x3_buf.sv
// Bench for demux_1x3_buf: directed vector table, hand sequences, then random traffic vs a slot model.
// Latency: outputs compared on the falling edge after each rising edge.
// Backpressure: random consumer readiness exercises full/drain/load-wins cases.
module tb_demux_1x3_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivld;
  logic [1:0]  sel;
  logic [15:0] din;
  logic [2:0]  ordy;

  logic        in_ready, sat_in_ready;
  logic [15:0] out_00, out_01, out_10, s_out_00, s_out_01, s_out_10;
  logic        ov_00, ov_01, ov_10, s_ov_00, s_ov_01, s_ov_10;
  logic [7:0]  count_00, count_01, count_10;
  logic [1:0]  s_cnt_00, s_cnt_01, s_cnt_10;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_1x3_buf #(.DATA_WIDTH(16), .COUNT_WIDTH(8)) dut (
    .clk(clk), .reset(rst), .demux_in(din), .select_1x3(sel), .in_valid(ivld),
    .in_ready(in_ready),
    .out_00(out_00), .out_01(out_01), .out_10(out_10),
    .out_valid_00(ov_00), .out_valid_01(ov_01), .out_valid_10(ov_10),
    .out_ready_00(ordy[0]), .out_ready_01(ordy[1]), .out_ready_10(ordy[2]),
    .count_00(count_00), .count_01(count_01), .count_10(count_10)
  );

  demux_1x3_buf #(.DATA_WIDTH(16), .COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(rst), .demux_in(din), .select_1x3(sel), .in_valid(ivld),
    .in_ready(sat_in_ready),
    .out_00(s_out_00), .out_01(s_out_01), .out_10(s_out_10),
    .out_valid_00(s_ov_00), .out_valid_01(s_ov_01), .out_valid_10(s_ov_10),
    .out_ready_00(ordy[0]), .out_ready_01(ordy[1]), .out_ready_10(ordy[2]),
    .count_00(s_cnt_00), .count_01(s_cnt_01), .count_10(s_cnt_10)
  );

  logic [15:0] o_dat [3];
  logic        o_vld [3];
  logic [7:0]  o_cnt [3];
  logic [1:0]  s_cnt [3];
  assign o_dat[0] = out_00;   assign o_dat[1] = out_01;   assign o_dat[2] = out_10;
  assign o_vld[0] = ov_00;    assign o_vld[1] = ov_01;    assign o_vld[2] = ov_10;
  assign o_cnt[0] = count_00; assign o_cnt[1] = count_01; assign o_cnt[2] = count_10;
  assign s_cnt[0] = s_cnt_00; assign s_cnt[1] = s_cnt_01; assign s_cnt[2] = s_cnt_10;

  // Reference model: each slot is "holding a word or not", plus an unbounded accept tally.
  logic        m_vld [3];
  logic [15:0] m_dat [3];
  int          m_cnt [3];

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: inputs are already driven; checks in_ready before the edge and all slots after it.
  task automatic cycle(input string nm, output logic irdy_seen);
    int   t;
    logic exp_rdy;
    logic acc;
    t       = sel[1] ? 2 : (sel[0] ? 1 : 0);
    exp_rdy = !rst && (!m_vld[t] || ordy[t]);
    #1;
    irdy_seen = in_ready;
    chk({nm, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
    chk({nm, ".sat_in_ready"}, {31'd0, sat_in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    acc = ivld && exp_rdy;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_vld[k] = 1'b0;
        m_dat[k] = '0;
        m_cnt[k] = 0;
      end else if (acc && k == t) begin
        m_vld[k] = 1'b1;
        m_dat[k] = din;
        m_cnt[k] = m_cnt[k] + 1;
      end else if (m_vld[k] && ordy[k]) begin
        m_vld[k] = 1'b0;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.vld%0d", nm, k), {31'd0, o_vld[k]}, {31'd0, m_vld[k]});
      chk($sformatf("%s.dat%0d", nm, k), {16'd0, o_dat[k]}, {16'd0, m_dat[k]});
      chk($sformatf("%s.cnt%0d", nm, k), {24'd0, o_cnt[k]}, min_i(m_cnt[k], 255));
      chk($sformatf("%s.satcnt%0d", nm, k), {30'd0, s_cnt[k]}, min_i(m_cnt[k], 3));
    end
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic [2:0]  ordy;      // bit0 slot 00, bit1 slot 01, bit2 slot 10
    logic        exp_irdy;
    logic [2:0]  exp_ovld;
    int          slot;
    logic [15:0] exp_dat;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [10];
  logic irdy;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 2'b00, 16'h1111, 3'b000, 1'b0, 3'b000, 0, 16'h0000, 0};
    tbl[1] = '{1'b0, 1'b1, 2'b00, 16'h1234, 3'b000, 1'b1, 3'b001, 0, 16'h1234, 1};
    tbl[2] = '{1'b0, 1'b1, 2'b01, 16'h2222, 3'b000, 1'b1, 3'b011, 1, 16'h2222, 1};
    tbl[3] = '{1'b0, 1'b1, 2'b01, 16'h3333, 3'b000, 1'b0, 3'b011, 1, 16'h2222, 1};
    tbl[4] = '{1'b0, 1'b1, 2'b10, 16'h4444, 3'b000, 1'b1, 3'b111, 2, 16'h4444, 1};
    tbl[5] = '{1'b0, 1'b1, 2'b11, 16'hBEEF, 3'b100, 1'b1, 3'b111, 2, 16'hBEEF, 2};
    tbl[6] = '{1'b0, 1'b1, 2'b00, 16'hAAAA, 3'b001, 1'b1, 3'b111, 0, 16'hAAAA, 2};
    tbl[7] = '{1'b0, 1'b1, 2'b00, 16'h5555, 3'b001, 1'b1, 3'b111, 0, 16'h5555, 3};
    tbl[8] = '{1'b0, 1'b0, 2'b00, 16'h6666, 3'b011, 1'b1, 3'b100, 0, 16'h5555, 3};
    tbl[9] = '{1'b1, 1'b1, 2'b10, 16'h7777, 3'b000, 1'b0, 3'b000, 2, 16'h0000, 0};

    for (int k = 0; k < 3; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = '0;
      m_cnt[k] = 0;
    end
    rst = 1'b1; ivld = 1'b0; sel = 2'b00; din = '0; ordy = 3'b000;
    @(negedge clk);

    // Directed vectors: basic load, full-slot stall, select 11, load-wins drain, reset mid-traffic.
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; ivld = tbl[i].vld; sel = tbl[i].sel;
      din = tbl[i].dat; ordy = tbl[i].ordy;
      cycle($sformatf("vec%0d", i), irdy);
      chk($sformatf("vec%0d.tbl_irdy", i), {31'd0, irdy}, {31'd0, tbl[i].exp_irdy});
      chk($sformatf("vec%0d.tbl_ovld", i), {29'd0, o_vld[2], o_vld[1], o_vld[0]}, {29'd0, tbl[i].exp_ovld});
      chk($sformatf("vec%0d.tbl_dat", i), {16'd0, o_dat[tbl[i].slot]}, {16'd0, tbl[i].exp_dat});
      chk($sformatf("vec%0d.tbl_cnt", i), {24'd0, o_cnt[tbl[i].slot]}, tbl[i].exp_cnt);
    end

    // Stream 10 back-to-back words into slot 00 with the consumer always ready.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ivld = 1'b1; sel = 2'b00; din = 16'h0100 + 16'(i); ordy = 3'b001;
      cycle($sformatf("stream%0d", i), irdy);
      chk($sformatf("stream%0d.accepted", i), {31'd0, irdy}, 32'd1);
    end
    chk("stream.count_00", {24'd0, count_00}, 32'd10);
    chk("stream.out_00", {16'd0, out_00}, 32'h0109);

    // Drain slot 00 and leave it idle: data must hold after valid drops.
    ivld = 1'b0; ordy = 3'b001;
    cycle("drain", irdy);
    chk("drain.out_00_hold", {16'd0, out_00}, 32'h0109);

    // Saturation: 5 words into slot 01; the 2-bit counter sticks at 3.
    rst = 1'b1; ivld = 1'b0; ordy = 3'b000;
    cycle("sat_rst", irdy);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ivld = 1'b1; sel = 2'b01; din = 16'hC000 + 16'(i); ordy = 3'b010;
      cycle($sformatf("sat%0d", i), irdy);
    end
    chk("sat.count_01_2bit", {30'd0, s_cnt_01}, 32'd3);
    chk("sat.count_01_8bit", {24'd0, count_01}, 32'd5);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      ivld = $urandom_range(0, 3) != 0;
      sel  = 2'($urandom_range(0, 3));
      din  = 16'($urandom);
      ordy = 3'($urandom_range(0, 7));
      cycle($sformatf("rnd%0d", i), irdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1x3_buf.md
Name: demux_1x3_buf

Overview:
Registered 1-to-3 demultiplexer. It is the distribution-side counterpart of the datapath 3:1 selectors. It takes one DATA_WIDTH word with a 2-bit select and delivers it to one of three output slots, each a one-entry holding register with a valid/ready handshake. It sits between a single producer (ALU/bus result) and three independent consumers (e.g. register file, memory write port, I/O), and decouples their back-pressure.

Parameters:
DATA_WIDTH, 16, width of data word and of every output slot
COUNT_WIDTH, 8, width of each per-slot saturating transfer counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
demux_in  input  DATA_WIDTH  input data word
select_1x3  input  2  target slot select: 00 -> slot 00, 01 -> slot 01, 10 or 11 -> slot 10
in_valid  input  1  producer has a word on demux_in/select_1x3
in_ready  output  1  block can accept the word this cycle
out_00, out_01, out_10  output  DATA_WIDTH each  slot data registers
out_valid_00, out_valid_01, out_valid_10  output  1 each  slot holds an undelivered word
out_ready_00, out_ready_01, out_ready_10  input  1 each  consumer takes the slot word this cycle
count_00, count_01, count_10  output  COUNT_WIDTH each  accepted-word counters per slot

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). While reset is high at a rising edge, the following clear on that edge: all out_valid_*, all out_* data, and all count_*.
- in_ready is forced 0 while reset is high.
- Slot decode mirrors the 3:1 mux priority: select_1x3[1]=1 selects slot 10 regardless of bit 0; otherwise bit 0 selects slot 01 (1) or slot 00 (0).
- in_ready is combinational: in_ready = !reset && (!out_valid_t || out_ready_t), where t is the decoded slot. There is no combinational path from demux_in to any output.
- Accept: in_valid && in_ready at a rising edge. On accept:
  - out_t <= demux_in
  - out_valid_t <= 1
  - count_t <= count_t + 1, saturating at 2^COUNT_WIDTH-1 (no wrap)
- Drain of slot k: out_valid_k && out_ready_k at an edge. If slot k is not loaded in the same edge, out_valid_k <= 0 and out_k holds its value.
- Simultaneous drain and load of the same slot: the load wins. out_valid stays 1, the new word replaces the old, and the old word counts as delivered. This gives full throughput of 1 word/cycle per slot.
- Slots are independent. Drains of untargeted slots proceed in the same cycle as an accept to another slot. Up to 3 drains plus 1 accept can occur per cycle.
- Stability: while out_valid_k=1 and out_ready_k=0, out_k must not change. in_valid with in_ready=0 causes no state change; the producer holds the word.
- Latency: an accepted word is visible on out_t with out_valid_t=1 in the cycle after acceptance.
- Reset mid-operation: any held words are discarded, with no delivery and no counter change other than the clear.
- out_ready_* while out_valid_*=0 is ignored.
- select_1x3 is don't-care when in_valid=0.

Test Plan:
1. Reset, then demux_in=16'h1234, select=00, in_valid=1, all out_ready=0 -> in_ready=1; next cycle out_00=1234, out_valid_00=1, count_00=1; out_valid_01/10 stay 0.
2. Slot 01 full (out_ready_01=0), present select=01 -> in_ready=0, out_01 unchanged. Present select=10 in the same state -> in_ready=1, and out_10 loads next cycle.
3. select=11, demux_in=16'hBEEF -> out_10=BEEF, out_valid_10=1, count_10 increments; slot 00/01 untouched.
4. Slot 00 valid with AAAA, out_ready_00=1, and in the same cycle accept 5555 to slot 00 -> next cycle out_00=5555, out_valid_00=1, count_00 increments by 1. Streaming 10 back-to-back words with out_ready_00=1 -> all accepted, count_00=10.
5. All slots valid, assert reset for one edge with in_valid=1 -> all out_valid=0, out_*=0, count_*=0, no accept. in_ready=0 during reset.
6. COUNT_WIDTH=2: accept 5 words into slot 01 -> count_01 sticks at 3.
